// File: rtl/ifu_fetch_ctrl_if.sv
// Fetch-controller bundle: redirect, imem request/response, downstream instruction and fetch PC.
// The master modport is the fetch controller; the slave side is the memory, downstream and redirect source.
interface ifu_fetch_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic             redirect_valid;
  logic [WIDTH-1:0] redirect_pc;
  logic             imem_req_valid;
  logic             imem_req_ready;
  logic [WIDTH-1:0] imem_req_addr;
  logic             imem_resp_valid;
  logic [WIDTH-1:0] imem_resp_data;
  logic             imem_resp_err;
  logic             inst_valid;
  logic             inst_ready;
  logic [WIDTH-1:0] inst;
  logic [WIDTH-1:0] inst_pc;
  logic             inst_err;
  logic [WIDTH-1:0] pc;

  modport master (
    input  redirect_valid, redirect_pc, imem_req_ready,
           imem_resp_valid, imem_resp_data, imem_resp_err, inst_ready,
    output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, inst_err, pc
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready,
           imem_resp_valid, imem_resp_data, imem_resp_err, inst_ready,
    input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, inst_err, pc
  );
endinterface

// File: rtl/ifu_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, keeps one imem request in flight,
// hands instructions downstream and squashes in-flight fetches on redirect.
module ifu_fetch_ctrl #(
  parameter int unsigned     WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h8000_0000)
) (
  input  logic                 clk,
  input  logic                 rst,
  ifu_fetch_ctrl_if.master     bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_OUT  = 2'd3
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] pc_q;
  logic             kill_q;
  logic [WIDTH-1:0] inst_q;
  logic [WIDTH-1:0] inst_pc_q;
  logic             inst_err_q;

  logic             req_fire;
  logic [WIDTH-1:0] redirect_pc_aligned;

  assign req_fire            = (state_q == S_REQ) && bus.imem_req_ready;
  assign redirect_pc_aligned = bus.redirect_pc & ~WIDTH'(3);

  // Sequencer; the redirect PC write sits last so it overrides the pc+4 advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      kill_q     <= 1'b0;
      inst_q     <= '0;
      inst_pc_q  <= '0;
      inst_err_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: state_q <= S_REQ;
        S_REQ: begin
          if (req_fire) begin
            state_q <= S_WAIT;
            if (bus.redirect_valid) kill_q <= 1'b1;
          end
        end
        S_WAIT: begin
          if (bus.imem_resp_valid) begin
            if (kill_q || bus.redirect_valid) begin
              kill_q  <= 1'b0;
              state_q <= S_REQ;
            end else begin
              inst_q     <= bus.imem_resp_data;
              inst_pc_q  <= pc_q;
              inst_err_q <= bus.imem_resp_err;
              state_q    <= S_OUT;
            end
          end else if (bus.redirect_valid) begin
            kill_q <= 1'b1;
          end
        end
        S_OUT: begin
          if (bus.redirect_valid) begin
            state_q <= S_REQ;
          end else if (bus.inst_ready) begin
            pc_q    <= pc_q + WIDTH'(4);
            state_q <= S_REQ;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      if (bus.redirect_valid) pc_q <= redirect_pc_aligned;
    end
  end

  // Handshake valids decode straight from the state register.
  assign bus.imem_req_valid = (state_q == S_REQ);
  assign bus.inst_valid     = (state_q == S_OUT);
  assign bus.imem_req_addr  = pc_q;
  assign bus.pc             = pc_q;
  assign bus.inst           = inst_q;
  assign bus.inst_pc        = inst_pc_q;
  assign bus.inst_err       = inst_err_q;

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Directed bench for ifu_fetch_ctrl: cycle-exact scenarios with hand-computed expectations.
module tb_ifu_fetch_ctrl;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  ifu_fetch_ctrl_if #(.WIDTH(32)) bus ();

  ifu_fetch_ctrl #(.WIDTH(32), .RESET_PC(32'h8000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle before driving or sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (bus.pc !== 32'h8000_0000) begin errors++; $display("FAIL reset_pc: got %h exp %h", bus.pc, 32'h8000_0000); end
    checks++; if (bus.imem_req_addr !== 32'h8000_0000) begin errors++; $display("FAIL reset_addr: got %h exp %h", bus.imem_req_addr, 32'h8000_0000); end
    checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b exp 0", bus.imem_req_valid); end
    checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid: got %b exp 0", bus.inst_valid); end
    checks++; if (bus.inst !== 32'h0 || bus.inst_pc !== 32'h0 || bus.inst_err !== 1'b0) begin errors++; $display("FAIL reset_inst_regs: got inst=%h pc=%h err=%b exp 0/0/0", bus.inst, bus.inst_pc, bus.inst_err); end
    rst = 1'b0;
    tick();
    checks++; if (bus.imem_req_valid !== 1'b1) begin errors++; $display("FAIL idle_to_req: got %b exp 1", bus.imem_req_valid); end
  endtask

  task automatic test_free_run();
    logic [31:0] data [3];
    logic [31:0] exp_addr;
    data[0] = 32'h0000_0013;
    data[1] = 32'h00A0_0093;
    data[2] = 32'hFFF1_0113;
    bus.imem_req_ready = 1'b1;
    bus.inst_ready     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_addr = 32'h8000_0000 + 32'(i * 4);
      checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== exp_addr) begin errors++; $display("FAIL free_req%0d: got v=%b a=%h exp v=1 a=%h", i, bus.imem_req_valid, bus.imem_req_addr, exp_addr); end
      tick();
      checks++; if (bus.imem_req_valid !== 1'b0 || bus.inst_valid !== 1'b0) begin errors++; $display("FAIL free_wait%0d: got req=%b inst=%b exp 0/0", i, bus.imem_req_valid, bus.inst_valid); end
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = data[i];
      tick();
      bus.imem_resp_valid = 1'b0;
      checks++; if (bus.inst_valid !== 1'b1 || bus.inst !== data[i] || bus.inst_pc !== exp_addr || bus.inst_err !== 1'b0) begin errors++; $display("FAIL free_out%0d: got v=%b inst=%h pc=%h err=%b exp 1/%h/%h/0", i, bus.inst_valid, bus.inst, bus.inst_pc, bus.inst_err, data[i], exp_addr); end
      tick();
    end
  endtask

  task automatic test_stall();
    bus.inst_ready = 1'b0;
    checks++; if (bus.imem_req_addr !== 32'h8000_000C) begin errors++; $display("FAIL stall_start_addr: got %h exp %h", bus.imem_req_addr, 32'h8000_000C); end
    tick();
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data  = 32'hAAAA_5555;
    tick();
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = 32'h0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.inst_valid !== 1'b1 || bus.imem_req_valid !== 1'b0 || bus.inst !== 32'hAAAA_5555 || bus.inst_pc !== 32'h8000_000C) begin errors++; $display("FAIL stall_hold%0d: got v=%b req=%b inst=%h pc=%h exp 1/0/aaaa5555/8000000c", i, bus.inst_valid, bus.imem_req_valid, bus.inst, bus.inst_pc); end
      tick();
    end
    bus.inst_ready = 1'b1;
    tick();
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h8000_0010 || bus.inst_valid !== 1'b0) begin errors++; $display("FAIL stall_release: got req=%b a=%h inst=%b exp 1/80000010/0", bus.imem_req_valid, bus.imem_req_addr, bus.inst_valid); end
  endtask

  task automatic test_redirect_wait();
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_1002;
    tick();
    bus.redirect_valid = 1'b0;
    checks++; if (bus.pc !== 32'h8000_1000 || bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL rdw_pc: got pc=%h req=%b exp 80001000/0", bus.pc, bus.imem_req_valid); end
    tick();
    tick();
    checks++; if (bus.inst_valid !== 1'b0 || bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL rdw_still_wait: got inst=%b req=%b exp 0/0", bus.inst_valid, bus.imem_req_valid); end
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data  = 32'hDEAD_BEEF;
    tick();
    bus.imem_resp_valid = 1'b0;
    checks++; if (bus.inst_valid !== 1'b0 || bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h8000_1000) begin errors++; $display("FAIL rdw_dropped: got inst=%b req=%b a=%h exp 0/1/80001000", bus.inst_valid, bus.imem_req_valid, bus.imem_req_addr); end
    tick();
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data  = 32'h1111_0001;
    tick();
    bus.imem_resp_valid = 1'b0;
    checks++; if (bus.inst_valid !== 1'b1 || bus.inst !== 32'h1111_0001 || bus.inst_pc !== 32'h8000_1000) begin errors++; $display("FAIL rdw_refetch: got v=%b inst=%h pc=%h exp 1/11110001/80001000", bus.inst_valid, bus.inst, bus.inst_pc); end
    tick();
  endtask

  task automatic test_redirect_edges();
    // Redirect in the acceptance cycle.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_2000;
    tick();
    bus.redirect_valid = 1'b0;
    checks++; if (bus.pc !== 32'h8000_2000 || bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL rda_pc: got pc=%h req=%b exp 80002000/0", bus.pc, bus.imem_req_valid); end
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data  = 32'hBAD0_BAD0;
    tick();
    bus.imem_resp_valid = 1'b0;
    checks++; if (bus.inst_valid !== 1'b0 || bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h8000_2000) begin errors++; $display("FAIL rda_killed: got inst=%b req=%b a=%h exp 0/1/80002000", bus.inst_valid, bus.imem_req_valid, bus.imem_req_addr); end
    tick();
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data  = 32'h2222_2222;
    tick();
    bus.imem_resp_valid = 1'b0;
    checks++; if (bus.inst_valid !== 1'b1 || bus.inst !== 32'h2222_2222 || bus.inst_pc !== 32'h8000_2000) begin errors++; $display("FAIL rda_refetch: got v=%b inst=%h pc=%h exp 1/22222222/80002000", bus.inst_valid, bus.inst, bus.inst_pc); end
    // Redirect together with inst_ready in OUT: target wins over pc+4.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_3007;
    tick();
    bus.redirect_valid = 1'b0;
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h8000_3004 || bus.inst_valid !== 1'b0) begin errors++; $display("FAIL rdo_target: got req=%b a=%h inst=%b exp 1/80003004/0", bus.imem_req_valid, bus.imem_req_addr, bus.inst_valid); end
    // Redirect in REQ before acceptance: address moves, state holds.
    bus.imem_req_ready = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_4001;
    tick();
    bus.redirect_valid = 1'b0;
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h8000_4000) begin errors++; $display("FAIL rdr_move: got req=%b a=%h exp 1/80004000", bus.imem_req_valid, bus.imem_req_addr); end
    tick();
    checks++; if (bus.imem_req_valid !== 1'b1) begin errors++; $display("FAIL rdr_hold: got req=%b exp 1", bus.imem_req_valid); end
  endtask

  task automatic test_fault();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0004;
    tick();
    bus.redirect_valid = 1'b0;
    bus.imem_req_ready = 1'b1;
    tick();
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data  = 32'h0;
    bus.imem_resp_err   = 1'b1;
    tick();
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_err   = 1'b0;
    checks++; if (bus.inst_valid !== 1'b1 || bus.inst_err !== 1'b1 || bus.inst_pc !== 32'h8000_0004) begin errors++; $display("FAIL fault_out: got v=%b err=%b pc=%h exp 1/1/80000004", bus.inst_valid, bus.inst_err, bus.inst_pc); end
    tick();
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h8000_0008) begin errors++; $display("FAIL fault_next: got req=%b a=%h exp 1/80000008", bus.imem_req_valid, bus.imem_req_addr); end
    tick();
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data  = 32'h0000_1234;
    tick();
    bus.imem_resp_valid = 1'b0;
    checks++; if (bus.inst_valid !== 1'b1 || bus.inst_err !== 1'b0 || bus.inst_pc !== 32'h8000_0008 || bus.inst !== 32'h0000_1234) begin errors++; $display("FAIL fault_clear: got v=%b err=%b pc=%h inst=%h exp 1/0/80000008/00001234", bus.inst_valid, bus.inst_err, bus.inst_pc, bus.inst); end
    tick();
  endtask

  task automatic test_wrap();
    bus.imem_req_ready = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFE;
    tick();
    bus.redirect_valid = 1'b0;
    bus.imem_req_ready = 1'b1;
    checks++; if (bus.imem_req_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_start: got %h exp fffffffc", bus.imem_req_addr); end
    tick();
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data  = 32'h5A5A_5A5A;
    tick();
    bus.imem_resp_valid = 1'b0;
    tick();
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0000_0000) begin errors++; $display("FAIL wrap_next: got req=%b a=%h exp 1/00000000", bus.imem_req_valid, bus.imem_req_addr); end
  endtask

  task automatic test_reset_midwait();
    tick();
    checks++; if (bus.imem_req_valid !== 1'b0 || bus.inst_valid !== 1'b0) begin errors++; $display("FAIL rstw_in_wait: got req=%b inst=%b exp 0/0", bus.imem_req_valid, bus.inst_valid); end
    rst = 1'b1;
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data  = 32'hCAFE_F00D;
    tick();
    rst = 1'b0;
    checks++; if (bus.inst_valid !== 1'b0 || bus.imem_req_valid !== 1'b0 || bus.pc !== 32'h8000_0000) begin errors++; $display("FAIL rstw_idle: got inst=%b req=%b pc=%h exp 0/0/80000000", bus.inst_valid, bus.imem_req_valid, bus.pc); end
    tick();
    bus.imem_resp_valid = 1'b0;
    checks++; if (bus.inst_valid !== 1'b0 || bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h8000_0000) begin errors++; $display("FAIL rstw_req: got inst=%b req=%b a=%h exp 0/1/80000000", bus.inst_valid, bus.imem_req_valid, bus.imem_req_addr); end
    tick();
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data  = 32'h7777_0000;
    tick();
    bus.imem_resp_valid = 1'b0;
    checks++; if (bus.inst_valid !== 1'b1 || bus.inst !== 32'h7777_0000 || bus.inst_pc !== 32'h8000_0000) begin errors++; $display("FAIL rstw_first: got v=%b inst=%h pc=%h exp 1/77770000/80000000", bus.inst_valid, bus.inst, bus.inst_pc); end
    tick();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst                 = 1'b1;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = 32'h0;
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = 32'h0;
    bus.imem_resp_err   = 1'b0;
    bus.inst_ready      = 1'b0;
    #1;
    test_reset();
    test_free_run();
    test_stall();
    test_redirect_wait();
    test_redirect_edges();
    test_fault();
    test_wrap();
    test_reset_midwait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout exp completion");
    $fatal(1);
  end

endmodule
